ir_receiver: RTL
================

IR_RECEIVER -- requirements
Module: ir_receiver

Interface
REQ-001 SHALL have parameter MESSAGE_LENGTH, default 5, payload bits per frame.
REQ-002 SHALL have parameter UNIT_CYCLES, default 56250, clock cycles per timing unit (562.5 us at 100 MHz).
REQ-003 SHALL have parameter FILTER_CYCLES, default 16, cycles a level must hold before the filter accepts it.
REQ-004 clk_in  input  1  single system clock, 100 MHz.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 signal_in  input  1  raw demodulator output, asynchronous to clk_in; low = carrier present (mark), high = space.
REQ-007 data_out  output  MESSAGE_LENGTH  last good payload; holds until the next good frame.
REQ-008 data_valid_out  output  1  one-cycle pulse when data_out updates.
REQ-009 error_out  output  1  one-cycle pulse on any framing or timing violation.
REQ-010 busy_out  output  1  high in every state except IDLE.

Function
REQ-011 signal_in SHALL pass through a 2-flop synchronizer, then a glitch filter; the filtered level changes only after the synchronized level differs from it for FILTER_CYCLES consecutive cycles.
REQ-012 The frame SHALL be: start mark 16 units; start space 8 units; MESSAGE_LENGTH bits, LSB first, each a 1-unit mark plus a space of 1 unit (0) or 3 units (1); stop mark 1 unit.
REQ-013 A segment of nominal N units SHALL be accepted when its measured length L satisfies floor(0.75*N*UNIT_CYCLES) <= L <= floor(1.25*N*UNIT_CYCLES).
REQ-014 The segment counter SHALL reset on every filtered edge, saturate at 20*UNIT_CYCLES, and be $clog2(20*UNIT_CYCLES+1) bits wide.
REQ-015 States SHALL be IDLE, START_MARK, START_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, WAIT_IDLE.
REQ-016 IDLE -> START_MARK on a filtered falling edge; START_MARK -> START_SPACE on a rising edge with a valid 16-unit length; START_SPACE -> BIT_MARK on a falling edge with a valid 8-unit length.
REQ-017 BIT_MARK -> BIT_SPACE on a rising edge with a valid 1-unit length; BIT_SPACE -> BIT_MARK (or STOP_MARK after the last bit) on a falling edge, shifting in 0 for a valid 1-unit space or 1 for a valid 3-unit space.
REQ-018 STOP_MARK -> IDLE on a rising edge with a valid 1-unit length; data_out loads and data_valid_out pulses in the cycle after that edge is detected.
REQ-019 An invalid length at any edge, or a segment reaching saturation outside IDLE, SHALL pulse error_out once and enter WAIT_IDLE.
REQ-020 WAIT_IDLE -> IDLE only after the filtered line has been high for 8 continuous units; falling edges during WAIT_IDLE restart that count.
REQ-021 A partial or errored frame SHALL never modify data_out.
REQ-022 data_valid_out and error_out SHALL never be high in the same cycle.

Reset
REQ-023 On rst_in: state = IDLE, data_out = 0, data_valid_out = 0, error_out = 0, busy_out = 0, counters and shift register = 0, synchronizer and filter state = 1 (idle high).
REQ-024 Reset asserted mid-frame SHALL abandon the frame without pulsing either output; decoding resumes at the next falling edge after release.

Configuration
REQ-025 With IR_RX_PARITY_EN defined, one even-parity bit, encoded like a data bit, SHALL follow the payload; a parity mismatch at the stop-mark edge SHALL pulse error_out instead of data_valid_out.
REQ-026 Without IR_RX_PARITY_EN, the frame SHALL be exactly as in REQ-012, and no parity logic SHALL be present.

Structure
REQ-027 Package ir_pkg SHALL hold the state enum and the unit-multiple constants (16, 8, 1, 3, 20, 8) shared with ir_transmitter; cycle-count thresholds SHALL be localparams in ir_receiver.
REQ-028 The synchronizer and glitch filter SHALL be one sub-module, ir_rx_filter.

Verification (UNIT_CYCLES=10, FILTER_CYCLES=2 unless stated)
REQ-029 Nominal frame with payload 5'b10110 -> data_out = 5'h16 with a single data_valid_out pulse after the stop mark; busy_out is low afterwards.
REQ-030 Start mark of 100 cycles (below the 120-cycle minimum) -> one error_out pulse; data_out unchanged; busy_out stays high until 80 idle cycles have elapsed.
REQ-031 1-cycle low glitches injected into spaces, plus all segments stretched to +20%, with payload 5'h1F -> data_out = 5'h1F and no error.
REQ-032 rst_in asserted after bit 2 of a frame, then a clean frame with payload 5'h03 -> no pulses from the first frame; data_out = 5'h03.
REQ-033 Line held low for 250 cycles in BIT_MARK -> error_out pulses at saturation (200 cycles); no valid pulse.
REQ-034 IR_RX_PARITY_EN defined: payload 5'h07 with parity 1 -> valid pulse; same frame with parity 0 -> error_out only.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: receiver FSM states and frame timing in units, shared
// with ir_transmitter; helpers derive the accepted length window.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_MARK,
    START_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    WAIT_IDLE
  } ir_state_t;

  localparam int START_MARK_UNITS  = 16;
  localparam int START_SPACE_UNITS = 8;
  localparam int BIT_MARK_UNITS    = 1;
  localparam int ZERO_SPACE_UNITS  = 1;
  localparam int ONE_SPACE_UNITS   = 3;
  localparam int STOP_MARK_UNITS   = 1;
  localparam int SAT_UNITS         = 20;
  localparam int IDLE_UNITS        = 8;

  // Segment of n units is accepted between 75% and 125%.
  function automatic int len_min(input int n, input int unit);
    return (3 * n * unit) / 4;
  endfunction

  function automatic int len_max(input int n, input int unit);
    return (5 * n * unit) / 4;
  endfunction

endpackage

// File: rtl/ir_rx_filter.sv
// ir_rx_filter: 2-flop synchronizer plus glitch filter for the IR line.
// Ports: clk_in, rst_in (async high), signal_in (raw line),
// level (filtered), rise/fall (1-cycle pulses as level changes).
module ir_rx_filter #(
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic signal_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], signal_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          rise  <= sync[1];
          fall  <= ~sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ir_receiver.sv
// ir_receiver: pulse-distance IR frame decoder (start, LSB-first bits,
// stop). Ports: clk_in, rst_in (async high), signal_in (low = mark),
// data_out, data_valid_out, error_out, busy_out.
// Option: define IR_RX_PARITY_EN for a trailing even-parity bit.
module ir_receiver
  import ir_pkg::*;
#(
  parameter int MESSAGE_LENGTH = 5,
  parameter int UNIT_CYCLES    = 56250,
  parameter int FILTER_CYCLES  = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      signal_in,
  output logic [MESSAGE_LENGTH-1:0] data_out,
  output logic                      data_valid_out,
  output logic                      error_out,
  output logic                      busy_out
);

  localparam int SAT_CYC = SAT_UNITS * UNIT_CYCLES;
  localparam int CW = $clog2(SAT_CYC + 1);
`ifdef IR_RX_PARITY_EN
  localparam int NB = MESSAGE_LENGTH + 1;
`else
  localparam int NB = MESSAGE_LENGTH;
`endif
  localparam int BW = $clog2(NB + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t SM_LO =
    cnt_t'(len_min(START_MARK_UNITS, UNIT_CYCLES));
  localparam cnt_t SM_HI =
    cnt_t'(len_max(START_MARK_UNITS, UNIT_CYCLES));
  localparam cnt_t SS_LO =
    cnt_t'(len_min(START_SPACE_UNITS, UNIT_CYCLES));
  localparam cnt_t SS_HI =
    cnt_t'(len_max(START_SPACE_UNITS, UNIT_CYCLES));
  localparam cnt_t BM_LO =
    cnt_t'(len_min(BIT_MARK_UNITS, UNIT_CYCLES));
  localparam cnt_t BM_HI =
    cnt_t'(len_max(BIT_MARK_UNITS, UNIT_CYCLES));
  localparam cnt_t PM_LO =
    cnt_t'(len_min(STOP_MARK_UNITS, UNIT_CYCLES));
  localparam cnt_t PM_HI =
    cnt_t'(len_max(STOP_MARK_UNITS, UNIT_CYCLES));
  localparam cnt_t B0_LO =
    cnt_t'(len_min(ZERO_SPACE_UNITS, UNIT_CYCLES));
  localparam cnt_t B0_HI =
    cnt_t'(len_max(ZERO_SPACE_UNITS, UNIT_CYCLES));
  localparam cnt_t B1_LO =
    cnt_t'(len_min(ONE_SPACE_UNITS, UNIT_CYCLES));
  localparam cnt_t B1_HI =
    cnt_t'(len_max(ONE_SPACE_UNITS, UNIT_CYCLES));
  localparam cnt_t SAT = cnt_t'(SAT_CYC);
  localparam cnt_t IDLE_LEN = cnt_t'(IDLE_UNITS * UNIT_CYCLES);
  localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);

  ir_state_t     state;
  cnt_t          seg_cnt;
  logic [NB-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic          level;
  logic          rise;
  logic          fall;
  logic          any_edge;
  logic          sat;
  logic          ok_sm;
  logic          ok_ss;
  logic          ok_bm;
  logic          ok_pm;
  logic          ok_b0;
  logic          ok_b1;

  ir_rx_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .signal_in(signal_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  assign any_edge = rise | fall;
  assign sat   = (seg_cnt == SAT);
  assign ok_sm = (seg_cnt >= SM_LO) && (seg_cnt <= SM_HI);
  assign ok_ss = (seg_cnt >= SS_LO) && (seg_cnt <= SS_HI);
  assign ok_bm = (seg_cnt >= BM_LO) && (seg_cnt <= BM_HI);
  assign ok_pm = (seg_cnt >= PM_LO) && (seg_cnt <= PM_HI);
  assign ok_b0 = (seg_cnt >= B0_LO) && (seg_cnt <= B0_HI);
  assign ok_b1 = (seg_cnt >= B1_LO) && (seg_cnt <= B1_HI);

  // Restarts at 1 on an edge so that, when the next edge
  // arrives, it holds the exact length of the segment.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      seg_cnt <= '0;
    end else if (any_edge) begin
      seg_cnt <= cnt_t'(1);
    end else if (!sat) begin
      seg_cnt <= seg_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
      busy_out       <= 1'b0;
      shreg          <= '0;
      bit_cnt        <= '0;
    end else begin
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state    <= START_MARK;
            busy_out <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        START_MARK: begin
          if (rise && ok_sm) begin
            state <= START_SPACE;
          end else if (rise || sat) begin
            error_out <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        START_SPACE: begin
          if (fall && ok_ss) begin
            state <= BIT_MARK;
          end else if (fall || sat) begin
            error_out <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        BIT_MARK: begin
          if (rise && ok_bm) begin
            state <= BIT_SPACE;
          end else if (rise || sat) begin
            error_out <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        BIT_SPACE: begin
          if (fall && (ok_b0 || ok_b1)) begin
            // LSB arrives first, so shift in from the top.
            shreg <= {ok_b1, shreg[NB-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state <= STOP_MARK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= BIT_MARK;
            end
          end else if (fall || sat) begin
            error_out <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        STOP_MARK: begin
          if (rise && ok_pm) begin
            state    <= IDLE;
            busy_out <= 1'b0;
`ifdef IR_RX_PARITY_EN
            if (^shreg) begin
              error_out <= 1'b1;
            end else begin
              data_out       <= shreg[MESSAGE_LENGTH-1:0];
              data_valid_out <= 1'b1;
            end
`else
            data_out       <= shreg;
            data_valid_out <= 1'b1;
`endif
          end else if (rise || sat) begin
            error_out <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // Any fall restarts seg_cnt, so this needs an
          // unbroken high stretch.
          if (level && !any_edge && seg_cnt >= IDLE_LEN) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
